// File: rtl/seg_pkg.sv
// Shared types, constants and BCD step helper for the two-digit seven-segment counter.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_WAIT,
        ST_REPEAT
    } rpt_state_t;

    localparam bcd_t        BCD_MAX             = 4'd9;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_REPEAT_DELAY    = 12500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;

    // Returns {tens, ones} after one up or down step, wrapping 99<->00.
    function automatic logic [7:0] bcd_step(input logic up, input bcd_t tens, input bcd_t ones);
        bcd_t t;
        bcd_t o;
        t = tens;
        o = ones;
        if (up) begin
            if (o == BCD_MAX) begin
                o = 4'd0;
                t = (t == BCD_MAX) ? 4'd0 : t + 4'd1;
            end else begin
                o = o + 4'd1;
            end
        end else begin
            if (o == 4'd0) begin
                o = BCD_MAX;
                t = (t == 4'd0) ? BCD_MAX : t - 4'd1;
            end else begin
                o = o - 4'd1;
            end
        end
        return {t, o};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and one-cycle
// press/release pulses aligned with the debounced level change.
module btn_debounce
    import seg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_sync;

    assign w_sync = r_sync[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sync != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level   <= w_sync;
                    r_cnt     <= '0;
                    r_press   <= w_sync;
                    r_release <= ~w_sync;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                // Any return to the accepted level restarts the stability window.
                r_cnt <= '0;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/seg_counter_ctrl.sv
// Two-digit BCD up/down counter control with debounced buttons.
// Define SEG_AUTO_REPEAT_EN to compile in hold-to-repeat (WAIT/REPEAT states and timer).
module seg_counter_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW_UP,
    input  logic       SW_DN,
    input  logic       SW_CLR,
    output logic [3:0] TENS,
    output logic [3:0] ONES,
    output logic       TENS_BLANK,
    output logic       STEP
);

    logic w_up_lvl, w_up_press, w_up_rel;
    logic w_dn_lvl, w_dn_press, w_dn_rel;
    logic w_clr_lvl, w_clr_press, w_clr_rel;
    logic w_start;
    logic w_leave;

    rpt_state_t r_state;
    bcd_t       r_tens;
    bcd_t       r_ones;
    logic       r_step;
    logic       r_dir;
`ifdef SEG_AUTO_REPEAT_EN
    logic [31:0] r_timer;
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .i_clk(CLK), .i_rst(RST), .i_btn(SW_UP),
        .o_level(w_up_lvl), .o_press(w_up_press), .o_release(w_up_rel)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .i_clk(CLK), .i_rst(RST), .i_btn(SW_DN),
        .o_level(w_dn_lvl), .o_press(w_dn_press), .o_release(w_dn_rel)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .i_clk(CLK), .i_rst(RST), .i_btn(SW_CLR),
        .o_level(w_clr_lvl), .o_press(w_clr_press), .o_release(w_clr_rel)
    );

    assign w_start = (w_up_press & ~w_dn_lvl) | (w_dn_press & ~w_up_lvl);
    assign w_leave = r_dir ? (w_up_rel | w_dn_press) : (w_dn_rel | w_up_press);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_tens  <= '0;
            r_ones  <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
`ifdef SEG_AUTO_REPEAT_EN
            r_timer <= '0;
`endif
        end else begin
            r_step <= 1'b0;
            if (w_clr_press) begin
                r_tens  <= '0;
                r_ones  <= '0;
                r_step  <= 1'b1;
                r_state <= ST_IDLE;
            end else if (w_clr_lvl || w_clr_rel) begin
                // The release cycle of clear still counts as held.
                r_state <= ST_IDLE;
            end else if (r_state != ST_IDLE && w_leave) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            {r_tens, r_ones} <= bcd_step(w_up_lvl, r_tens, r_ones);
                            r_step <= 1'b1;
                            r_dir  <= w_up_lvl;
`ifdef SEG_AUTO_REPEAT_EN
                            r_timer <= REPEAT_DELAY - 1;
                            r_state <= ST_WAIT;
`else
                            r_state <= ST_HELD;
`endif
                        end
                    end
`ifdef SEG_AUTO_REPEAT_EN
                    ST_WAIT, ST_REPEAT: begin
                        if (r_timer == '0) begin
                            {r_tens, r_ones} <= bcd_step(r_dir, r_tens, r_ones);
                            r_step  <= 1'b1;
                            r_timer <= REPEAT_PERIOD - 1;
                            r_state <= ST_REPEAT;
                        end else begin
                            r_timer <= r_timer - 32'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign TENS       = r_tens;
    assign ONES       = r_ones;
    assign TENS_BLANK = (r_tens == 4'd0);
    assign STEP       = r_step;

endmodule

// File: doc/seg_counter_ctrl.md
# seg_counter_ctrl

Control block for the two-digit seven-segment counter display. Debounces the up, down and clear push-buttons and sequences a BCD up/down count 00-99, with optional hold-to-repeat. It drives tens/ones digit codes to the existing per-digit seven-segment decoders, and replaces the free-running slow-clock stepping with single-clock, edge-qualified control.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles (10 ms @ 25 MHz) before a button level is accepted.
- REPEAT_DELAY, 12500000: hold time before auto-repeat starts (0.5 s).
- REPEAT_PERIOD, 2500000: cycles between repeated steps (0.1 s).
- CLK  input  1  system clock; all logic in this single clock domain.
- RST  input  1  asynchronous, active-high reset.
- SW_UP  input  1  raw up button, active-high, asynchronous to CLK.
- SW_DN  input  1  raw down button, active-high, asynchronous to CLK.
- SW_CLR  input  1  raw clear button, active-high, asynchronous to CLK.
- TENS  output  4  tens digit, BCD 0-9.
- ONES  output  4  ones digit, BCD 0-9.
- TENS_BLANK  output  1  high when TENS==0, for leading-zero blanking.
- STEP  output  1  one-cycle pulse on every count change, including clear.

## Operation
- Each button: 2-FF synchronizer, then debounce counter. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets the counter.
- Rising edge of debounced level = press event; falling edge = release.
- Priority: clear > (up XOR down). Both up and down debounced high = no step, and the repeat FSM returns to IDLE.
- Repeat FSM states:
  - IDLE: on a press of exactly one direction, step once, load timer with REPEAT_DELAY, go to WAIT.
  - WAIT: timer expires -> step, load REPEAT_PERIOD, go to REPEAT.
  - REPEAT: each expiry -> step, reload REPEAT_PERIOD.
  - Release of the active direction, or the other direction pressed -> IDLE from any state.
- Count arithmetic is two-digit BCD:
  - Up: ONES 9 -> 0 with TENS+1; 99 -> 00.
  - Down: ONES 0 -> 9 with TENS-1; 00 -> 99.
  - Digits never leave 0-9.
- Clear press: count -> 00, FSM -> IDLE. While clear is held, up/down steps are suppressed.

## Timing
- Reset values: TENS=0, ONES=0, TENS_BLANK=1, STEP=0, FSM=IDLE, all debounced levels 0, timers 0.
- RST assertion takes effect immediately and is valid mid-hold or mid-debounce. After release, a button already held must debounce again before it counts as a press.
- Latency, raw edge to count change: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. TENS/ONES update and STEP pulses in the same cycle.
- Repeat steps occur REPEAT_DELAY cycles after the first step, then every REPEAT_PERIOD cycles, each ±1 cycle-exact relative to the previous step.
- STEP is exactly one cycle wide. There is at most one step per cycle.
- Outputs are registered; no combinational path from inputs.

## Configuration
- SEG_AUTO_REPEAT_EN defined: WAIT/REPEAT states and the repeat timer are compiled in, as described above.
- Undefined: the FSM is IDLE/HELD only, giving exactly one step per press. REPEAT_DELAY and REPEAT_PERIOD remain as parameters but are unused.

## Structure
- Shared package seg_pkg:
  - BCD digit typedef (4-bit).
  - Repeat FSM state enum.
  - Constants BCD_MAX=9 and default timing values.
- Sub-module: btn_debounce (synchronizer + debounce counter + press/release pulses). Instantiated three times.
- Top holds the FSM, repeat timer and BCD counter.

## Test plan
All scenarios use small parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset, then idle 50 cycles -> TENS=0, ONES=0, TENS_BLANK=1, STEP never high.
- SW_UP pulse with 3-cycle bounce glitches, then stable high 10 cycles -> exactly one STEP; count 01 at cycle 2+4+1 after the stable edge.
- Preload 99 by stepping, then press up -> 00 with TENS_BLANK=1. Press down -> 99.
- Hold SW_DN from 05 for 40 cycles (SEG_AUTO_REPEAT_EN defined) -> steps at t0, t0+20, t0+25, t0+30, t0+35 -> final count 00. Without the macro -> only 04.
- Hold up, then press down -> no step while both are held. Release down -> no new step until up is re-pressed.
- Clear held during up auto-repeat -> 00, STEP pulse once, no further steps. Assert RST mid-repeat -> all outputs reset immediately.
